pkt_mux: RTL
============

PKT_MUX -- requirements
Module: pkt_mux

Interface
REQ-001 Parameter DATA_W, default 8: width of every data bus.
REQ-002 Parameter CNT_W, default 16: width of the per-input packet counters.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Ports s0_valid, s0_last  input  1 each: source 0 beat valid; last beat of packet.
REQ-006 Port s0_data  input  DATA_W: source 0 beat payload.
REQ-007 Port s0_ready  output  1: source 0 beat accepted when s0_valid && s0_ready.
REQ-008 Ports s1_valid, s1_last, s1_data, s1_ready: same as REQ-005..007, for source 1.
REQ-009 Port m_valid, m_last  output  1 each: registered output beat valid; last beat.
REQ-010 Port m_data  output  DATA_W: registered output payload, to the downstream sink stage.
REQ-011 Port m_ready  input  1: downstream accepts the output beat when m_valid && m_ready; may toggle every cycle.
REQ-012 Port grant  output  2: one-hot current owner (01=s0, 10=s1, 00=idle).
REQ-013 Ports pkt_cnt0, pkt_cnt1  output  CNT_W each: packets fully forwarded per source.

Function
REQ-014 The FSM SHALL have three states: IDLE, GNT0, GNT1; grant mirrors the state.
REQ-015 In IDLE, the FSM SHALL move to GNT0 if only s0_valid, to GNT1 if only s1_valid, and to GNT<rr> if both are valid; it SHALL stay in IDLE if neither is valid.
REQ-016 The 1-bit pointer rr SHALL name the preferred source; at each packet end it SHALL be set to the other source.
REQ-017 s0_ready SHALL be (state==GNT0) && (!m_valid || m_ready), and s1_ready likewise for GNT1; an input not granted SHALL see ready=0.
REQ-018 On an accepted input beat, m_valid/m_last/m_data SHALL load that beat on the next edge (latency 1 cycle).
REQ-019 If m_valid && m_ready with no new input beat accepted, m_valid SHALL clear next edge; m_data SHALL hold its value.
REQ-020 While m_valid && !m_ready, m_valid/m_last/m_data SHALL be held stable.
REQ-021 A grant SHALL be held for a whole packet; it SHALL end only when a beat with last=1 is accepted from the granted input, which returns the FSM to IDLE on the same edge.
REQ-022 The FSM SHALL spend exactly one IDLE cycle between packets; that cycle is the only point where the owner can change.
REQ-023 Sustained throughput within a packet SHALL be one beat per cycle while m_ready=1.
REQ-024 pkt_cntN SHALL increment when a last=1 beat from source N is accepted at the input; it SHALL wrap from all-ones to 0.
REQ-025 A single-beat packet (valid and last in the same beat) SHALL be legal and SHALL count as one packet.
REQ-026 A non-granted source deasserting valid while waiting SHALL have no effect; no beat SHALL be dropped, duplicated or reordered.

Reset
REQ-027 While rst_n=0: state=IDLE, rr=0, m_valid=0, m_last=0, m_data=0, grant=00, pkt_cnt0=pkt_cnt1=0, s0_ready=s1_ready=0.
REQ-028 Assertion of reset mid-packet SHALL abandon the packet and discard any held output beat; after release the block SHALL arbitrate from IDLE.

Verification
REQ-029 Reset: rst_n=0 asserted asynchronously mid-packet -> all outputs take their REQ-027 values with no clock edge.
REQ-030 Single source: s0 sends 3 beats 0x11,0x22,0x33 (last on 0x33), m_ready=1 -> m_data is 0x11,0x22,0x33 on consecutive cycles, m_last on 0x33 only, pkt_cnt0=1.
REQ-031 Contention: s0 and s1 both valid with 2-beat packets (0xA0,0xA1 / 0xB0,0xB1), rr=0 -> output order A0,A1,B0,B1 with one bubble between packets; grant 01 then 10.
REQ-032 Backpressure: m_ready toggles 1,0,1,0 during a 4-beat s1 packet -> each beat is held stable while m_ready=0; all 4 beats are delivered in order; s1_ready=0 whenever the output is full and m_ready=0.
REQ-033 Packet lock: s1 becomes valid during the 2nd beat of a 4-beat s0 packet -> s1_ready stays 0 until the s0 last beat is accepted; s1 is granted after one IDLE cycle.
REQ-034 Wrap: with CNT_W=2, send 5 single-beat s0 packets -> pkt_cnt0 reads 1,2,3,0,1.

Source files
------------

// File: rtl/pkt_mux.sv
// pkt_mux: two-source packet multiplexer with a round-robin packet-level
// arbiter and a single registered output stage.
// A grant is held for a whole packet and released only by an accepted last
// beat, followed by exactly one IDLE cycle.
// Each source has a packet counter that wraps.
module pkt_mux #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  input  logic              s0_last,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic              s1_last,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              m_valid,
  output logic              m_last,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  // The encoding is one-hot, so the grant output is the state register itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              mvalid_q, mvalid_d;
  logic              mlast_q, mlast_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic out_free;
  logic acc0, acc1;

  // The output register can take a beat when it is empty or is being drained.
  assign out_free = !mvalid_q || m_ready;
  assign s0_ready = (state_q == GNT0) && out_free;
  assign s1_ready = (state_q == GNT1) && out_free;
  assign acc0     = s0_valid && s0_ready;
  assign acc1     = s1_valid && s1_ready;

  assign m_valid  = mvalid_q;
  assign m_last   = mlast_q;
  assign m_data   = mdata_q;
  assign grant    = state_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

  // Arbitration and packet lock: choose an owner in IDLE, release it on its accepted last beat.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) begin
          state_d = rr_q ? GNT1 : GNT0;
        end else if (s0_valid) begin
          state_d = GNT0;
        end else if (s1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (acc0 && s0_last) begin
          state_d = IDLE;
          rr_d    = 1'b1;
        end
      end
      GNT1: begin
        if (acc1 && s1_last) begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Output stage: load on accept, drop valid on drain, otherwise hold.
  always_comb begin
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;
    mdata_d  = mdata_q;
    if (acc0) begin
      mvalid_d = 1'b1;
      mlast_d  = s0_last;
      mdata_d  = s0_data;
    end else if (acc1) begin
      mvalid_d = 1'b1;
      mlast_d  = s1_last;
      mdata_d  = s1_data;
    end else if (mvalid_q && m_ready) begin
      mvalid_d = 1'b0;
    end
  end

  // Output register; reset discards any beat still held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      mdata_q  <= '0;
    end else begin
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      mdata_q  <= mdata_d;
    end
  end

  // Packet counters advance when a last beat is taken at the input; they wrap naturally.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && s0_last) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (acc1 && s1_last) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  // Packet counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

endmodule
